debounce_bank: RTL and testbench

Parametrised N-channel debouncer for the piano key inputs. Each channel synchronises a raw switch or key line, qualifies it with a saturating stability counter, and emits a clean level plus single-cycle press/release pulses. A registered lowest-index key encoder feeds the tone selector. An optional per-channel auto-repeat generator is compiled in by macro.

---
 rtl/debounce_pkg.sv | 31 +++
 rtl/debounce_bank_if.sv | 25 ++
 rtl/debounce_chan.sv | 140 ++++++++++++++
 rtl/debounce_bank.sv | 71 +++++++
 tb/tb_debounce_bank.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/debounce_pkg.sv
// Shared types, constants and helpers for the debounce bank.
// The auto-repeat state enum is used only when DEBOUNCE_REPEAT_EN is defined.
package debounce_pkg;

   localparam int CNT_W_SYN = 22;
   localparam int CNT_W_SIM = 11;
   localparam int N_MAX     = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_RATE  = 2'd2
   } rpt_state_t;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Index of the lowest set bit, 0 when no bit is set.
   function automatic int lowest_set_idx(input logic [N_MAX-1:0] v);
      int idx;
      idx = 0;
      for (int i = N_MAX - 1; i >= 0; i--) begin
         if (v[i]) begin
            idx = i;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/debounce_bank_if.sv
// Key-line bundle between a raw key source (master) and the debounce bank (slave).
interface debounce_bank_if #(
   parameter int N    = 8,
   parameter int ID_W = debounce_pkg::id_width(N)
);

   logic [N-1:0]    INPUT;
   logic [N-1:0]    D_OUT;
   logic [N-1:0]    PRESS;
   logic [N-1:0]    RELEASE;
   logic [N-1:0]    REPEAT;
   logic            KEY_VALID;
   logic [ID_W-1:0] KEY_ID;

   modport master (
      output INPUT,
      input  D_OUT, PRESS, RELEASE, REPEAT, KEY_VALID, KEY_ID
   );

   modport slave (
      input  INPUT,
      output D_OUT, PRESS, RELEASE, REPEAT, KEY_VALID, KEY_ID
   );

endinterface

// File: rtl/debounce_chan.sv
// One debounce channel: synchroniser, saturating stability counter, level and edge pulses.
// Auto-repeat generator is built only when DEBOUNCE_REPEAT_EN is defined.
module debounce_chan
   import debounce_pkg::*;
#(
   parameter int CNT_W      = CNT_W_SYN,
   parameter int SYNC       = 2,
   parameter int RPT_DELAY  = 1 << 24,
   parameter int RPT_PERIOD = 1 << 22
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_in,
   output logic d_out,
   output logic d_out_next,
   output logic press,
   output logic rls,
   output logic rpt
);

   if (SYNC < 2 || CNT_W < 2 || RPT_DELAY < 1 || RPT_PERIOD < 1) begin : g_bad_param
      $error("debounce_chan: illegal parameter combination");
   end

   logic [SYNC-1:0]  sync_q, sync_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             d_out_q, d_out_d;
   logic             press_q, press_d;
   logic             rls_q, rls_d;
   logic             differ;
   logic             stable;

   // Counter clears whenever the two oldest sync stages disagree, so the
   // level is only adopted after a full threshold of identical samples.
   always_comb begin
      sync_d  = {sync_q[SYNC-2:0], raw_in};
      differ  = sync_q[SYNC-1] ^ sync_q[SYNC-2];
      stable  = cnt_q[CNT_W-1];
      cnt_d   = cnt_q;
      if (differ) begin
         cnt_d = '0;
      end else if (!stable) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      d_out_d = stable ? sync_q[SYNC-1] : d_out_q;
      press_d = d_out_d & ~d_out_q;
      rls_d   = ~d_out_d & d_out_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         d_out_q <= 1'b0;
         press_q <= 1'b0;
         rls_q   <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         d_out_q <= d_out_d;
         press_q <= press_d;
         rls_q   <= rls_d;
      end
   end

   assign d_out      = d_out_q;
   assign d_out_next = d_out_d;
   assign press      = press_q;
   assign rls        = rls_q;

`ifdef DEBOUNCE_REPEAT_EN
   localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
   localparam int RC_W    = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

   rpt_state_t      state_q, state_d;
   logic [RC_W-1:0] rc_q, rc_d;
   logic            rpt_q, rpt_d;
   logic            delay_done;
   logic            rate_done;

   assign delay_done = (rc_q == RC_W'(RPT_DELAY - 1));
   assign rate_done  = (rc_q == RC_W'(RPT_PERIOD - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         rc_q    <= '0;
         rpt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rc_q    <= rc_d;
         rpt_q   <= rpt_d;
      end
   end

   // Release wins over everything, then a fresh press restarts the delay.
   always_comb begin
      state_d = state_q;
      rc_d    = rc_q;
      if (!d_out_d) begin
         state_d = ST_IDLE;
         rc_d    = '0;
      end else if (press_d) begin
         state_d = ST_DELAY;
         rc_d    = '0;
      end else begin
         case (state_q)
            ST_DELAY: begin
               if (delay_done) begin
                  state_d = ST_RATE;
                  rc_d    = '0;
               end else begin
                  rc_d = rc_q + RC_W'(1);
               end
            end
            ST_RATE: begin
               rc_d = rate_done ? '0 : rc_q + RC_W'(1);
            end
            default: begin
               state_d = ST_IDLE;
               rc_d    = '0;
            end
         endcase
      end
   end

   always_comb begin
      rpt_d = 1'b0;
      if (d_out_d && !press_d) begin
         rpt_d = ((state_q == ST_DELAY) && delay_done) ||
                 ((state_q == ST_RATE)  && rate_done);
      end
   end

   assign rpt = rpt_q;
`else
   assign rpt = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// N-channel key debouncer with a registered lowest-index key encoder.
// Define DEBOUNCE_REPEAT_EN to build the per-channel auto-repeat generators.
module debounce_bank
   import debounce_pkg::*;
#(
   parameter int N          = 8,
   parameter int CNT_W      = CNT_W_SYN,
   parameter int SYNC       = 2,
   parameter int RPT_DELAY  = 1 << 24,
   parameter int RPT_PERIOD = 1 << 22,
   parameter int ID_W       = id_width(N)
) (
   input  logic            CLK,
   input  logic            RESET,
   debounce_bank_if.slave  bus
);

   if (N < 1 || N > N_MAX || ID_W < id_width(N)) begin : g_bad_param
      $error("debounce_bank: N must be 1..32 and ID_W wide enough");
   end

   logic [N-1:0]    d_out_w;
   logic [N-1:0]    d_out_next;
   logic [N-1:0]    press_w;
   logic [N-1:0]    rls_w;
   logic [N-1:0]    rpt_w;
   logic            key_valid_q, key_valid_d;
   logic [ID_W-1:0] key_id_q, key_id_d;

   for (genvar gi = 0; gi < N; gi++) begin : g_chan
      debounce_chan #(
         .CNT_W      (CNT_W),
         .SYNC       (SYNC),
         .RPT_DELAY  (RPT_DELAY),
         .RPT_PERIOD (RPT_PERIOD)
      ) u_chan (
         .clk        (CLK),
         .rst        (RESET),
         .raw_in     (bus.INPUT[gi]),
         .d_out      (d_out_w[gi]),
         .d_out_next (d_out_next[gi]),
         .press      (press_w[gi]),
         .rls        (rls_w[gi]),
         .rpt        (rpt_w[gi])
      );
   end

   // Encoder looks at the next level so KEY_* line up with D_OUT.
   always_comb begin
      key_valid_d = |d_out_next;
      key_id_d    = ID_W'(lowest_set_idx(N_MAX'(d_out_next)));
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         key_valid_q <= 1'b0;
         key_id_q    <= '0;
      end else begin
         key_valid_q <= key_valid_d;
         key_id_q    <= key_id_d;
      end
   end

   assign bus.D_OUT     = d_out_w;
   assign bus.PRESS     = press_w;
   assign bus.RELEASE   = rls_w;
   assign bus.REPEAT    = rpt_w;
   assign bus.KEY_VALID = key_valid_q;
   assign bus.KEY_ID    = key_id_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: N=4, threshold 8, SYNC=2, repeat delay 5 / period 3.
// Repeat expectations follow DEBOUNCE_REPEAT_EN as seen by this compile.
module tb_debounce_bank;
   import debounce_pkg::*;

   localparam int N = 4;

   logic CLK;
   logic RESET;
   int   vectors;
   int   miscompares;

   debounce_bank_if #(.N(N)) bus ();

   debounce_bank #(
      .N          (N),
      .CNT_W      (4),
      .SYNC       (2),
      .RPT_DELAY  (5),
      .RPT_PERIOD (3)
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      bus.INPUT = 4'hF;
      step(3);
      vectors++;
      if ({bus.D_OUT, bus.PRESS, bus.RELEASE, bus.REPEAT} !== 16'h0) begin
         miscompares++;
         $display("FAIL reset_vectors: got %h expected 0000", {bus.D_OUT, bus.PRESS, bus.RELEASE, bus.REPEAT});
      end
      vectors++;
      if ({bus.KEY_VALID, bus.KEY_ID} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_key: got %b expected 000", {bus.KEY_VALID, bus.KEY_ID});
      end
      RESET = 1'b0;
      step(10);
      vectors++;
      if (bus.D_OUT !== 4'h0 || bus.PRESS !== 4'h0) begin
         miscompares++;
         $display("FAIL reset_edge10: got d_out=%h press=%h expected 0/0", bus.D_OUT, bus.PRESS);
      end
      step(1);
      vectors++;
      if (bus.D_OUT !== 4'hF || bus.PRESS !== 4'hF) begin
         miscompares++;
         $display("FAIL reset_edge11: got d_out=%h press=%h expected f/f", bus.D_OUT, bus.PRESS);
      end
      vectors++;
      if (bus.KEY_VALID !== 1'b1 || bus.KEY_ID !== 2'd0) begin
         miscompares++;
         $display("FAIL reset_edge11_key: got valid=%b id=%0d expected 1/0", bus.KEY_VALID, bus.KEY_ID);
      end
      step(1);
      vectors++;
      if (bus.PRESS !== 4'h0 || bus.D_OUT !== 4'hF) begin
         miscompares++;
         $display("FAIL reset_press_width: got press=%h d_out=%h expected 0/f", bus.PRESS, bus.D_OUT);
      end
      bus.INPUT = 4'h0;
      step(11);
      vectors++;
      if (bus.RELEASE !== 4'hF || bus.D_OUT !== 4'h0 || bus.KEY_VALID !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release_all: got rel=%h d_out=%h valid=%b expected f/0/0", bus.RELEASE, bus.D_OUT, bus.KEY_VALID);
      end
      step(1);
      $display("test_reset done: %0d vectors so far", vectors);
   endtask

   task automatic test_clean_press();
      bus.INPUT = 4'b0010;
      step(10);
      vectors++;
      if (bus.D_OUT !== 4'h0) begin
         miscompares++;
         $display("FAIL press_early: got d_out=%h expected 0", bus.D_OUT);
      end
      step(1);
      vectors++;
      if (bus.D_OUT !== 4'b0010 || bus.PRESS !== 4'b0010 || bus.RELEASE !== 4'h0) begin
         miscompares++;
         $display("FAIL press_edge11: got d_out=%h press=%h rel=%h expected 2/2/0", bus.D_OUT, bus.PRESS, bus.RELEASE);
      end
      vectors++;
      if (bus.KEY_VALID !== 1'b1 || bus.KEY_ID !== 2'd1) begin
         miscompares++;
         $display("FAIL press_key: got valid=%b id=%0d expected 1/1", bus.KEY_VALID, bus.KEY_ID);
      end
      step(1);
      vectors++;
      if (bus.PRESS !== 4'h0 || bus.D_OUT !== 4'b0010) begin
         miscompares++;
         $display("FAIL press_width: got press=%h d_out=%h expected 0/2", bus.PRESS, bus.D_OUT);
      end
      bus.INPUT = 4'b0000;
      step(10);
      vectors++;
      if (bus.D_OUT !== 4'b0010 || bus.RELEASE !== 4'h0) begin
         miscompares++;
         $display("FAIL release_early: got d_out=%h rel=%h expected 2/0", bus.D_OUT, bus.RELEASE);
      end
      step(1);
      vectors++;
      if (bus.RELEASE !== 4'b0010 || bus.D_OUT !== 4'h0) begin
         miscompares++;
         $display("FAIL release_edge11: got rel=%h d_out=%h expected 2/0", bus.RELEASE, bus.D_OUT);
      end
      vectors++;
      if (bus.KEY_VALID !== 1'b0 || bus.KEY_ID !== 2'd0) begin
         miscompares++;
         $display("FAIL release_key: got valid=%b id=%0d expected 0/0", bus.KEY_VALID, bus.KEY_ID);
      end
      step(1);
      vectors++;
      if (bus.RELEASE !== 4'h0) begin
         miscompares++;
         $display("FAIL release_width: got rel=%h expected 0", bus.RELEASE);
      end
      $display("test_clean_press done: %0d vectors so far", vectors);
   endtask

   task automatic test_bounce();
      for (int t = 0; t < 10; t++) begin
         bus.INPUT[2] = ~bus.INPUT[2];
         for (int c = 0; c < 3; c++) begin
            step(1);
            vectors++;
            if (bus.D_OUT !== 4'h0 || bus.PRESS !== 4'h0 || bus.RELEASE !== 4'h0) begin
               miscompares++;
               $display("FAIL bounce_cycle%0d: got d_out=%h press=%h rel=%h expected 0/0/0", t * 3 + c, bus.D_OUT, bus.PRESS, bus.RELEASE);
            end
         end
      end
      bus.INPUT = 4'h0;
      for (int c = 0; c < 12; c++) begin
         step(1);
         vectors++;
         if (bus.D_OUT !== 4'h0 || bus.PRESS !== 4'h0 || bus.RELEASE !== 4'h0) begin
            miscompares++;
            $display("FAIL bounce_settle%0d: got d_out=%h press=%h rel=%h expected 0/0/0", c, bus.D_OUT, bus.PRESS, bus.RELEASE);
         end
      end
      $display("test_bounce done: %0d vectors so far", vectors);
   endtask

   task automatic test_simultaneous();
      bus.INPUT = 4'b1010;
      step(11);
      vectors++;
      if (bus.PRESS !== 4'b1010 || bus.D_OUT !== 4'b1010) begin
         miscompares++;
         $display("FAIL simul_press: got press=%h d_out=%h expected a/a", bus.PRESS, bus.D_OUT);
      end
      vectors++;
      if (bus.KEY_VALID !== 1'b1 || bus.KEY_ID !== 2'd1) begin
         miscompares++;
         $display("FAIL simul_key1: got valid=%b id=%0d expected 1/1", bus.KEY_VALID, bus.KEY_ID);
      end
      step(1);
      bus.INPUT = 4'b1000;
      step(10);
      vectors++;
      if (bus.KEY_ID !== 2'd1 || bus.RELEASE !== 4'h0) begin
         miscompares++;
         $display("FAIL simul_hold: got id=%0d rel=%h expected 1/0", bus.KEY_ID, bus.RELEASE);
      end
      step(1);
      vectors++;
      if (bus.RELEASE !== 4'b0010 || bus.D_OUT !== 4'b1000 || bus.KEY_ID !== 2'd3) begin
         miscompares++;
         $display("FAIL simul_rel1: got rel=%h d_out=%h id=%0d expected 2/8/3", bus.RELEASE, bus.D_OUT, bus.KEY_ID);
      end
      bus.INPUT = 4'b0000;
      step(11);
      vectors++;
      if (bus.RELEASE !== 4'b1000 || bus.KEY_VALID !== 1'b0 || bus.KEY_ID !== 2'd0) begin
         miscompares++;
         $display("FAIL simul_rel3: got rel=%h valid=%b id=%0d expected 8/0/0", bus.RELEASE, bus.KEY_VALID, bus.KEY_ID);
      end
      step(1);
      $display("test_simultaneous done: %0d vectors so far", vectors);
   endtask

   task automatic test_repeat();
      logic [3:0] exp_rpt;
      bus.INPUT = 4'b0001;
      step(11);
      vectors++;
      if (bus.PRESS !== 4'b0001 || bus.REPEAT !== 4'h0) begin
         miscompares++;
         $display("FAIL repeat_press: got press=%h rpt=%h expected 1/0", bus.PRESS, bus.REPEAT);
      end
      // Release is timed so the falling level lands on a would-be repeat edge (k=23).
      for (int k = 1; k <= 30; k++) begin
         if (k == 13) begin
            bus.INPUT = 4'b0000;
         end
         step(1);
         exp_rpt = 4'h0;
`ifdef DEBOUNCE_REPEAT_EN
         if (k >= 5 && k < 23 && ((k - 5) % 3) == 0) begin
            exp_rpt = 4'b0001;
         end
`endif
         vectors++;
         if (bus.REPEAT !== exp_rpt) begin
            miscompares++;
            $display("FAIL repeat_k%0d: got rpt=%h expected %h", k, bus.REPEAT, exp_rpt);
         end
         if (k == 23) begin
            vectors++;
            if (bus.RELEASE !== 4'b0001 || bus.D_OUT !== 4'h0) begin
               miscompares++;
               $display("FAIL repeat_release: got rel=%h d_out=%h expected 1/0", bus.RELEASE, bus.D_OUT);
            end
         end
      end
      $display("test_repeat done: %0d vectors so far", vectors);
   endtask

   task automatic test_reset_mid_count();
      bus.INPUT = 4'b0100;
      step(5);
      RESET = 1'b1;
      step(2);
      vectors++;
      if ({bus.D_OUT, bus.PRESS, bus.RELEASE, bus.REPEAT, bus.KEY_VALID} !== 17'h0) begin
         miscompares++;
         $display("FAIL midrst_hold: got %h expected 00000", {bus.D_OUT, bus.PRESS, bus.RELEASE, bus.REPEAT, bus.KEY_VALID});
      end
      RESET = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         step(1);
         vectors++;
         if (bus.D_OUT !== 4'h0 || bus.PRESS !== 4'h0 || bus.RELEASE !== 4'h0) begin
            miscompares++;
            $display("FAIL midrst_edge%0d: got d_out=%h press=%h rel=%h expected 0/0/0", k, bus.D_OUT, bus.PRESS, bus.RELEASE);
         end
      end
      step(1);
      vectors++;
      if (bus.D_OUT !== 4'b0100 || bus.PRESS !== 4'b0100 || bus.KEY_ID !== 2'd2 || bus.KEY_VALID !== 1'b1) begin
         miscompares++;
         $display("FAIL midrst_edge11: got d_out=%h press=%h id=%0d valid=%b expected 4/4/2/1", bus.D_OUT, bus.PRESS, bus.KEY_ID, bus.KEY_VALID);
      end
      $display("test_reset_mid_count done: %0d vectors so far", vectors);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      RESET       = 1'b1;
      bus.INPUT   = 4'hF;
      test_reset();
      test_clean_press();
      test_bounce();
      test_simultaneous();
      test_repeat();
      test_reset_mid_count();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
